alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter FLAGS_INIT, default 4'b0000, is the value loaded into the flags register on reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  an ALU result is presented this cycle.
REQ-005 in_ready  output  1  block can accept an input this cycle.
REQ-006 in_result  input  16  ALU result word.
REQ-007 in_flags  input  4  ALU flags: [3]=C, [2]=V, [1]=N, [0]=Z.
REQ-008 in_dest  input  3  destination register index.
REQ-009 in_set_flags  input  1  the accepted op updates the flags register.
REQ-010 out_valid  output  1  a writeback entry is presented to the register file.
REQ-011 out_ready  input  1  register file consumes the presented entry.
REQ-012 out_result  output  16  result of the oldest buffered entry.
REQ-013 out_dest  output  3  destination of the oldest buffered entry.
REQ-014 flags_q  output  4  architectural flags register.
REQ-015 cond_sel  input  3  condition selector for cond_true.
REQ-016 cond_true  output  1  selected condition evaluated on flags_q.

Function
REQ-017 The block SHALL hold a 2-entry in-order FIFO of {result, dest}; the entry count is 0, 1 or 2 (states EMPTY, ONE, FULL).
REQ-018 An input is accepted on a cycle with in_valid=1 and in_ready=1; an output is retired on a cycle with out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL be 1 exactly when the count at the start of the cycle is below 2; it does not depend combinationally on out_ready.
REQ-020 out_valid SHALL be 1 exactly when the count is at least 1; out_result and out_dest SHALL show the oldest entry and remain stable while out_valid=1 and out_ready=0.
REQ-021 Transitions: accept only -> count+1; retire only -> count-1; both in one cycle (possible only in ONE) -> count unchanged; the new entry becomes head on the next cycle.
REQ-022 Latency: an entry accepted in cycle N SHALL appear on out_* in cycle N+1 at the earliest; no combinational path from in_* to out_*.
REQ-023 In FULL, in_valid is ignored even when out_ready=1 in the same cycle; data is never dropped or overwritten.
REQ-024 Storage indices SHALL wrap modulo 2; ordering is preserved across any number of wraps.
REQ-025 On an accept with in_set_flags=1, flags_q SHALL take in_flags on the next cycle; otherwise flags_q holds. Flags update at accept, not at retirement.
REQ-026 cond_true is combinational from flags_q: 0 always 1; 1 Z; 2 not Z; 3 C; 4 not C; 5 N; 6 V; 7 N xor V (signed less-than).
REQ-027 in_* values on cycles without an accept SHALL have no effect on state.

Reset
REQ-028 While rst=1 at a rising edge: count becomes 0, flags_q becomes FLAGS_INIT, and out_valid is 0 on the following cycle.
REQ-029 in_ready SHALL be 0 during any cycle with rst=1; an accept or retirement coincident with rst is discarded.
REQ-030 A reset asserted in FULL or ONE discards all buffered entries; no stale entry appears after reset deasserts.
REQ-031 out_result and out_dest values while out_valid=0 are don't-care.

Verification
REQ-032 Single pass: accept {0x001E, dest 2, flags 0000, set 1} with out_ready=1 -> next cycle out_valid=1, out_result=0x001E, out_dest=2, flags_q=0000; cycle after, out_valid=0.
REQ-033 Flags/cond: accept {0xFFFE, flags 0110, set 1} -> flags_q=0110; cond_sel 5 -> 1, 6 -> 1, 7 -> 0, 1 -> 0; then accept {0x0000, flags 1001, set 0} -> flags_q stays 0110.
REQ-034 Backpressure: out_ready=0, push 0x0001, 0x0002, 0x0003 back-to-back -> in_ready drops after the 2nd accept; 0x0003 not taken; releasing out_ready yields 0x0001 then 0x0002 in order, then accepts 0x0003.
REQ-035 Simultaneous push/pop in ONE, repeated 10 cycles with incrementing data -> count stays 1, output sequence strictly incrementing, no gaps or duplicates across index wrap.
REQ-036 Reset mid-operation: FULL with flags_q=1010, assert rst one cycle with in_valid=1 and out_ready=1 -> out_valid=0, in_ready=1, flags_q=FLAGS_INIT, and neither the coincident input nor old entries ever appear.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry in-order skid FIFO of {result, dest} toward the
// register file, plus the architectural flags register and condition evaluator.
module alu_writeback #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic [3:0]  in_flags,
  input  logic [2:0]  in_dest,
  input  logic        in_set_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_dest,
  output logic [3:0]  flags_q,
  input  logic [2:0]  cond_sel,
  output logic        cond_true
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      state, state_next;
  logic [15:0] res_mem  [2];
  logic [2:0]  dest_mem [2];
  logic        wr_ptr, rd_ptr;
  logic        accept, retire;

  // Readiness depends only on registered occupancy, never on out_ready.
  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready && !rst;

  assign out_result = res_mem[rd_ptr];
  assign out_dest   = dest_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      flags_q <= FLAGS_INIT;
    end else begin
      state <= state_next;
      if (accept) begin
        wr_ptr <= ~wr_ptr;
        if (in_set_flags) flags_q <= in_flags;
      end
      if (retire) rd_ptr <= ~rd_ptr;
    end
  end

  // Payload storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      res_mem[wr_ptr]  <= in_result;
      dest_mem[wr_ptr] <= in_dest;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !retire)      state_next = FULL;
        else if (retire && !accept) state_next = EMPTY;
      end
      FULL:    if (retire) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // flags_q layout: [3]=C, [2]=V, [1]=N, [0]=Z
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flags_q[0];
      3'd2:    cond_true = ~flags_q[0];
      3'd3:    cond_true = flags_q[3];
      3'd4:    cond_true = ~flags_q[3];
      3'd5:    cond_true = flags_q[1];
      3'd6:    cond_true = flags_q[2];
      3'd7:    cond_true = flags_q[1] ^ flags_q[2];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus randomized traffic checked
// against a queue-based model of the writeback buffer and flags register.
module tb_alu_writeback;

  localparam logic [3:0] TB_INIT = 4'b0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic [3:0]  in_flags = '0;
  logic [2:0]  in_dest = '0;
  logic        in_set_flags = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic [3:0]  flags_q;
  logic [2:0]  cond_sel = '0;
  logic        cond_true;

  alu_writeback #(.FLAGS_INIT(TB_INIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_dest(in_dest), .in_set_flags(in_set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .flags_q(flags_q), .cond_sel(cond_sel),
    .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [18:0] mq [$];
  logic [3:0]  mflags = TB_INIT;

  // Observed values (sampled mid-cycle) and model expectations for that cycle
  logic        obs_ready, obs_valid, obs_cond;
  logic [15:0] obs_result;
  logic [2:0]  obs_dest;
  logic [3:0]  obs_flags;
  logic [26:0] exp_vec, obs_vec;

  function automatic logic cond_model(input logic [3:0] f, input logic [2:0] sel);
    logic c, v, n, z;
    {c, v, n, z} = f;
    case (sel)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return n;
      3'd6: return v;
      default: return n != v;
    endcase
  endfunction

  // One clock: sample outputs on the falling edge, advance the model with the
  // inputs then applied, then move past the rising edge.
  task automatic tick();
    logic acc, ret;
    @(negedge clk);
    obs_ready  = in_ready;
    obs_valid  = out_valid;
    obs_result = out_result;
    obs_dest   = out_dest;
    obs_flags  = flags_q;
    obs_cond   = cond_true;
    obs_vec = {obs_ready, obs_valid, obs_valid ? obs_result : 16'h0,
               obs_valid ? obs_dest : 3'h0, obs_flags, obs_cond};
    exp_vec = {!rst && (mq.size() < 2), mq.size() > 0,
               mq.size() > 0 ? mq[0][18:3] : 16'h0,
               mq.size() > 0 ? mq[0][2:0] : 3'h0,
               mflags, cond_model(mflags, cond_sel)};
    if (rst) begin
      mq.delete();
      mflags = TB_INIT;
    end else begin
      acc = in_valid && (mq.size() < 2);
      ret = (mq.size() > 0) && out_ready;
      if (ret) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({in_result, in_dest});
        if (in_set_flags) mflags = in_flags;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", obs_ready); end
    n_tests++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", obs_valid); end
    n_tests++;
    if (obs_flags !== TB_INIT) begin n_fail++; $display("FAIL reset_flags got %b want %b", obs_flags, TB_INIT); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got ready=%b valid=%b want ready=1 valid=0", obs_ready, obs_valid);
    end
  endtask

  task automatic test_single_pass();
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 16'h001E; in_dest = 3'd2; in_flags = 4'b0000; in_set_flags = 1'b1;
    tick();
    in_valid = 1'b0; in_result = 16'hDEAD; in_dest = 3'd7;
    tick();
    n_tests++;
    if ({obs_valid, obs_result, obs_dest, obs_flags} !== {1'b1, 16'h001E, 3'd2, 4'b0000}) begin
      n_fail++; $display("FAIL single_pass got v=%b r=%h d=%0d f=%b want v=1 r=001e d=2 f=0000",
                         obs_valid, obs_result, obs_dest, obs_flags);
    end
    tick();
    n_tests++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL single_pass_drain got valid=%b want 0", obs_valid); end
  endtask

  task automatic test_flags_cond();
    logic [2:0] sels [4] = '{3'd5, 3'd6, 3'd7, 3'd1};
    logic       want [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 16'hFFFE; in_dest = 3'd1; in_flags = 4'b0110; in_set_flags = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cond_sel = sels[i];
      tick();
      n_tests++;
      if (obs_flags !== 4'b0110 || obs_cond !== want[i]) begin
        n_fail++; $display("FAIL cond_sel%0d got flags=%b cond=%b want flags=0110 cond=%b",
                           sels[i], obs_flags, obs_cond, want[i]);
      end
    end
    in_valid = 1'b1; in_result = 16'h0000; in_flags = 4'b1001; in_set_flags = 1'b0;
    tick();
    in_valid = 1'b0; in_flags = 4'b1111; in_set_flags = 1'b1;
    tick();
    tick();
    n_tests++;
    if (obs_flags !== 4'b0110) begin n_fail++; $display("FAIL flags_hold got %b want 0110", obs_flags); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_set_flags = 1'b0; in_dest = 3'd3;
    in_valid = 1'b1;
    in_result = 16'h0001; tick();
    in_result = 16'h0002; tick();
    in_result = 16'h0003; tick();
    n_tests++;
    if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", obs_ready); end
    tick();
    n_tests++;
    if (obs_valid !== 1'b1 || obs_result !== 16'h0001) begin
      n_fail++; $display("FAIL bp_stall_head got v=%b r=%h want v=1 r=0001", obs_valid, obs_result);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if ({obs_ready, obs_valid, obs_result} !== {1'b0, 1'b1, 16'h0001}) begin
      n_fail++; $display("FAIL bp_first got rdy=%b v=%b r=%h want rdy=0 v=1 r=0001", obs_ready, obs_valid, obs_result);
    end
    tick();
    n_tests++;
    if ({obs_ready, obs_valid, obs_result} !== {1'b1, 1'b1, 16'h0002}) begin
      n_fail++; $display("FAIL bp_second got rdy=%b v=%b r=%h want rdy=1 v=1 r=0002", obs_ready, obs_valid, obs_result);
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (obs_valid !== 1'b1 || obs_result !== 16'h0003) begin
      n_fail++; $display("FAIL bp_third got v=%b r=%h want v=1 r=0003", obs_valid, obs_result);
    end
    tick();
    n_tests++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got valid=%b want 0", obs_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    base = 16'($urandom_range(0, 16'hFF00));
    out_ready = 1'b0; in_valid = 1'b1; in_result = base; in_dest = 3'd4;
    tick();
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 10; i++) begin
      in_result = base + 16'(i);
      tick();
      n_tests++;
      if ({obs_ready, obs_valid, obs_result} !== {1'b1, 1'b1, base + 16'(i - 1)}) begin
        n_fail++; $display("FAIL b2b_%0d got rdy=%b v=%b r=%h want rdy=1 v=1 r=%h",
                           i, obs_ready, obs_valid, obs_result, base + 16'(i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (obs_valid !== 1'b1 || obs_result !== base + 16'd10) begin
      n_fail++; $display("FAIL b2b_last got v=%b r=%h want v=1 r=%h", obs_valid, obs_result, base + 16'd10);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_set_flags = 1'b1; in_flags = 4'b1010;
    in_result = 16'hAAAA; in_dest = 3'd5; tick();
    in_set_flags = 1'b0; in_result = 16'hBBBB; tick();
    in_valid = 1'b0; tick();
    n_tests++;
    if ({obs_ready, obs_valid, obs_flags} !== {1'b0, 1'b1, 4'b1010}) begin
      n_fail++; $display("FAIL rst_mid_pre got rdy=%b v=%b f=%b want rdy=0 v=1 f=1010", obs_ready, obs_valid, obs_flags);
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_result = 16'hCCCC; in_set_flags = 1'b1; in_flags = 4'b1111;
    tick();
    n_tests++;
    if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready_in_reset got %b want 0", obs_ready); end
    rst = 1'b0; in_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({obs_ready, obs_valid, obs_flags} !== {1'b1, 1'b0, TB_INIT}) begin
        n_fail++; $display("FAIL rst_mid_post%0d got rdy=%b v=%b f=%b want rdy=1 v=0 f=%b",
                           i, obs_ready, obs_valid, obs_flags, TB_INIT);
      end
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      in_valid     = $urandom_range(0, 2) != 0;
      out_ready    = $urandom_range(0, 2) != 0;
      in_result    = 16'($urandom);
      in_dest      = 3'($urandom);
      in_flags     = 4'($urandom);
      in_set_flags = $urandom_range(0, 1) == 1;
      cond_sel     = 3'($urandom);
      tick();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL random_cycle%0d got %h want %h (rdy,v,res,dest,flags,cond)", i, obs_vec, exp_vec);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_flags_cond();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
